// File: rtl/xg_tmds_pkg.sv
// rtl/xg_tmds_pkg.sv - shared TMDS types, control tokens and popcount helper
package xg_tmds_pkg;

  typedef logic [9:0] tmds_sym_t;

  localparam tmds_sym_t CTRL_TOKEN_00 = 10'h354;
  localparam tmds_sym_t CTRL_TOKEN_01 = 10'h0AB;
  localparam tmds_sym_t CTRL_TOKEN_10 = 10'h154;
  localparam tmds_sym_t CTRL_TOKEN_11 = 10'h2AB;

  // Number of ones in a byte; 0..8 fits in 4 bits.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/xg_tmds_channel.sv
// rtl/xg_tmds_channel.sv - one TMDS channel: optional input reg, transition-minimise, DC-balance
module xg_tmds_channel
  import xg_tmds_pkg::*;
#(
  parameter int IN_REG = 1
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       de,
  input  logic       c0,
  input  logic       c1,
  output tmds_sym_t  q
);

  logic [7:0] s0_d;
  logic       s0_de;
  logic       s0_c0;
  logic       s0_c1;

  generate
    if (IN_REG != 0) begin : g_in_reg
      // Stage 0: plain input retiming, cleared to a control cycle.
      always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
          s0_d  <= '0;
          s0_de <= 1'b0;
          s0_c0 <= 1'b0;
          s0_c1 <= 1'b0;
        end else begin
          s0_d  <= d;
          s0_de <= de;
          s0_c0 <= c0;
          s0_c1 <= c1;
        end
      end
    end else begin : g_no_reg
      assign s0_d  = d;
      assign s0_de = de;
      assign s0_c0 = c0;
      assign s0_c1 = c1;
    end
  endgenerate

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_next;

  // Stage 1 combinational: choose XOR/XNOR chain to minimise transitions.
  always_comb begin
    n1d      = popcount8(s0_d);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !s0_d[0]);
    qm_next    = '0;
    qm_next[0] = s0_d[0];
    for (int i = 1; i < 8; i++) begin
      qm_next[i] = use_xnor ? ~(qm_next[i-1] ^ s0_d[i]) : (qm_next[i-1] ^ s0_d[i]);
    end
    qm_next[8] = ~use_xnor;
  end

  logic [8:0] s1_qm;
  logic [3:0] s1_n1q;
  logic       s1_de;
  logic       s1_c0;
  logic       s1_c1;

  // Stage 1 register: q_m plus its ones count so stage 2 needs no popcount.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      s1_qm  <= '0;
      s1_n1q <= '0;
      s1_de  <= 1'b0;
      s1_c0  <= 1'b0;
      s1_c1  <= 1'b0;
    end else begin
      s1_qm  <= qm_next;
      s1_n1q <= popcount8(qm_next[7:0]);
      s1_de  <= s0_de;
      s1_c0  <= s0_c0;
      s1_c1  <= s0_c1;
    end
  end

  // Running disparity, two's complement; stays even within -8..+8.
  logic [4:0] cnt;
  logic [4:0] cnt_next;
  logic [4:0] diff;
  logic       cnt_pos;
  logic       cnt_neg;
  logic       qm8;
  tmds_sym_t  q_next;

  // Stage 2 combinational: control token or DC-balanced data symbol.
  always_comb begin
    diff     = {s1_n1q, 1'b0} - 5'd8;
    cnt_neg  = cnt[4];
    cnt_pos  = !cnt[4] && (cnt != 5'd0);
    qm8      = s1_qm[8];
    q_next   = CTRL_TOKEN_00;
    cnt_next = cnt;
    if (!s1_de) begin
      case ({s1_c1, s1_c0})
        2'b00:   q_next = CTRL_TOKEN_00;
        2'b01:   q_next = CTRL_TOKEN_01;
        2'b10:   q_next = CTRL_TOKEN_10;
        default: q_next = CTRL_TOKEN_11;
      endcase
      cnt_next = 5'd0;
    end else if ((cnt == 5'd0) || (s1_n1q == 4'd4)) begin
      q_next   = {~qm8, qm8, qm8 ? s1_qm[7:0] : ~s1_qm[7:0]};
      cnt_next = qm8 ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && (s1_n1q > 4'd4)) || (cnt_neg && (s1_n1q < 4'd4))) begin
      q_next   = {1'b1, qm8, ~s1_qm[7:0]};
      cnt_next = cnt + {3'b000, qm8, 1'b0} - diff;
    end else begin
      q_next   = {1'b0, qm8, s1_qm[7:0]};
      cnt_next = cnt - {3'b000, ~qm8, 1'b0} + diff;
    end
  end

  // Stage 2 register: output symbol and disparity counter.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      q   <= CTRL_TOKEN_00;
      cnt <= 5'd0;
    end else begin
      q   <= q_next;
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/xg_tmds_encoder.sv
// rtl/xg_tmds_encoder.sv - three-channel DVI TMDS encoder top
module xg_tmds_encoder
  import xg_tmds_pkg::*;
#(
  parameter int IN_REG = 1
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       vde,
  input  logic       draw_hsync,
  input  logic       draw_vsync,
  input  logic [7:0] vga_r,
  input  logic [7:0] vga_g,
  input  logic [7:0] vga_b,
  output tmds_sym_t  tmds_r,
  output tmds_sym_t  tmds_g,
  output tmds_sym_t  tmds_b,
  output logic       de_out
);

  localparam int LAT = 2 + IN_REG;

  // Blue carries the syncs; red and green send the 00 token in blanking.
  xg_tmds_channel #(.IN_REG(IN_REG)) u_ch_b (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .d      (vga_b),
    .de     (vde),
    .c0     (draw_hsync),
    .c1     (draw_vsync),
    .q      (tmds_b)
  );

  xg_tmds_channel #(.IN_REG(IN_REG)) u_ch_g (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .d      (vga_g),
    .de     (vde),
    .c0     (1'b0),
    .c1     (1'b0),
    .q      (tmds_g)
  );

  xg_tmds_channel #(.IN_REG(IN_REG)) u_ch_r (
    .clk_25 (clk_25),
    .rst_n  (rst_n),
    .d      (vga_r),
    .de     (vde),
    .c0     (1'b0),
    .c1     (1'b0),
    .q      (tmds_r)
  );

  logic [LAT-1:0] de_pipe;

  // Delay vde by the channel latency so de_out frames the data symbols.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe <= '0;
    end else begin
      de_pipe <= {de_pipe[LAT-2:0], vde};
    end
  end

  assign de_out = de_pipe[LAT-1];

endmodule
